// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port CHIP-8 RAM between the ROM loader,
// the CPU core and the display/sprite fetcher. One access per cycle, with
// read data routed back one cycle later and a write-protected low region.
//
// Handshake: a requester holds req/addr/we/wdata stable until it sees its
// gnt; each gnt consumes exactly one access, and req may drop in the gnt
// cycle. For a granted read, rvalid_x is high exactly one cycle later while
// rdata carries ram_dout. Writes never produce rvalid.
module ram_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int PROT_LIMIT = 512
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_gnt,
   output logic              ld_rvalid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic              cpu_lock,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   input  logic              vid_req,
   input  logic              vid_lock,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              prot_err,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN_CPU = 2'd1,
      OWN_VID = 2'd2
   } state_e;

   // Comparison is done one bit wider so a limit of 2**ADDR_W still works.
   localparam logic [ADDR_W:0] PROT_LIM = (ADDR_W+1)'(PROT_LIMIT);

   state_e            state_q, state_d;
   logic              rr_vid_q, rr_vid_d;     // 1: video wins a CPU/video tie
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              ld_rvalid_q, ld_rvalid_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic              vid_rvalid_q, vid_rvalid_d;
   logic              prot_err_q, prot_err_d;

   logic              own_cpu, own_vid;
   logic              gnt_ld, gnt_cpu, gnt_vid;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_we;
   logic              sel_prot;

   // Ownership release, arbitration, next state and round-robin pointer.
   always_comb begin
      gnt_ld   = 1'b0;
      gnt_cpu  = 1'b0;
      gnt_vid  = 1'b0;
      state_d  = state_q;
      rr_vid_d = rr_vid_q;
      // A dropped lock releases ownership before this cycle's arbitration.
      own_cpu  = (state_q == OWN_CPU) && cpu_lock;
      own_vid  = (state_q == OWN_VID) && vid_lock;
      if (rst_n) begin
         if (own_cpu) begin
            gnt_cpu = cpu_req;
         end else if (own_vid) begin
            gnt_vid = vid_req;
         end else if (ld_req) begin
            gnt_ld = 1'b1;
         end else if (cpu_req && vid_req) begin
            gnt_vid = rr_vid_q;
            gnt_cpu = !rr_vid_q;
         end else begin
            gnt_cpu = cpu_req;
            gnt_vid = vid_req;
         end
      end
      if (own_cpu) begin
         state_d = OWN_CPU;
      end else if (own_vid) begin
         state_d = OWN_VID;
      end else if (gnt_cpu && cpu_lock) begin
         state_d = OWN_CPU;
      end else if (gnt_vid && vid_lock) begin
         state_d = OWN_VID;
      end else begin
         state_d = IDLE;
      end
      if (gnt_cpu) begin
         rr_vid_d = 1'b1;
      end else if (gnt_vid) begin
         rr_vid_d = 1'b0;
      end
   end

   // RAM port mux, write protection and read-return bookkeeping.
   always_comb begin
      sel_addr  = addr_q;
      sel_wdata = din_q;
      sel_we    = 1'b0;
      if (gnt_ld) begin
         sel_addr  = ld_addr;
         sel_wdata = ld_wdata;
         sel_we    = ld_we;
      end else if (gnt_cpu) begin
         sel_addr  = cpu_addr;
         sel_wdata = cpu_wdata;
         sel_we    = cpu_we;
      end else if (gnt_vid) begin
         sel_addr  = vid_addr;
      end
      sel_prot     = ({1'b0, sel_addr} < PROT_LIM);
      addr_d       = sel_addr;
      din_d        = sel_wdata;
      prot_err_d   = sel_we && sel_prot;
      ld_rvalid_d  = gnt_ld && !ld_we;
      cpu_rvalid_d = gnt_cpu && !cpu_we;
      vid_rvalid_d = gnt_vid;
   end

   // State, pointer, held RAM address/data and read-return flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         rr_vid_q     <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         ld_rvalid_q  <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         vid_rvalid_q <= 1'b0;
         prot_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_vid_q     <= rr_vid_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         ld_rvalid_q  <= ld_rvalid_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         vid_rvalid_q <= vid_rvalid_d;
         prot_err_q   <= prot_err_d;
      end
   end

   // Registered status is masked while reset is held so nothing leaks out.
   assign ld_gnt     = gnt_ld;
   assign cpu_gnt    = gnt_cpu;
   assign vid_gnt    = gnt_vid;
   assign ram_addr   = sel_addr;
   assign ram_din    = sel_wdata;
   assign ram_we     = sel_we && !sel_prot;
   assign rdata      = ram_dout;
   assign ld_rvalid  = ld_rvalid_q && rst_n;
   assign cpu_rvalid = cpu_rvalid_q && rst_n;
   assign vid_rvalid = vid_rvalid_q && rst_n;
   assign prot_err   = prot_err_q && rst_n;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand sequences for lock
// bursts and reset, then random traffic against a priority-list model.
module tb_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ld_req, ld_we, ld_gnt, ld_rvalid;
   logic [11:0] ld_addr;
   logic [7:0]  ld_wdata;
   logic        cpu_req, cpu_we, cpu_lock, cpu_gnt, cpu_rvalid;
   logic [11:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        vid_req, vid_lock, vid_gnt, vid_rvalid;
   logic [11:0] vid_addr;
   logic [7:0]  rdata;
   logic        prot_err;
   logic [11:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;
   logic [7:0]  ram_dout;

   int n_cmp  = 0;
   int n_fail = 0;

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   ram_arbiter #(.ADDR_W(12), .DATA_W(8), .PROT_LIMIT(512)) dut (
      .clk(clk), .rst_n(rst_n),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid),
      .vid_req(vid_req), .vid_lock(vid_lock), .vid_addr(vid_addr),
      .vid_gnt(vid_gnt), .vid_rvalid(vid_rvalid),
      .rdata(rdata), .prot_err(prot_err),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
      .ram_dout(ram_dout)
   );

   // Single-port RAM with one cycle of read latency.
   logic [7:0] ram_mem [4096];
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_dout <= ram_mem[ram_addr];
   end

   // Reference model state: memory image, owner (0 none, 1 cpu, 2 vid),
   // tie-break order, and what the next cycle should show.
   logic [7:0]  exp_mem [4096];
   int          m_owner;
   logic        m_vid_first;
   logic [2:0]  m_rv;
   logic [7:0]  m_rdata;
   logic        m_perr;
   logic [11:0] m_last;
   int          m_win;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Priority list: in free arbitration the loader comes first, then the
   // CPU/video pair in the order given by who was served least recently.
   task automatic model_step();
      int          win;
      int          own;
      int          order [3];
      logic        reqs [3];
      logic [11:0] a;
      logic        w;
      logic [7:0]  d;
      logic [2:0]  eg;
      win = -1; a = '0; w = 1'b0; d = '0;
      own = m_owner;
      if (own == 1 && !cpu_lock) own = 0;
      if (own == 2 && !vid_lock) own = 0;
      reqs[0] = ld_req; reqs[1] = cpu_req; reqs[2] = vid_req;
      order[0] = 0;
      order[1] = m_vid_first ? 2 : 1;
      order[2] = m_vid_first ? 1 : 2;
      if (rst_n) begin
         if (own != 0) begin
            if (reqs[own]) win = own;
         end else begin
            for (int i = 0; i < 3; i++)
               if (win < 0 && reqs[order[i]]) win = order[i];
         end
      end
      case (win)
         0: begin a = ld_addr; w = ld_we; d = ld_wdata; end
         1: begin a = cpu_addr; w = cpu_we; d = cpu_wdata; end
         2: begin a = vid_addr; end
         default: ;
      endcase
      eg = (win == 0) ? 3'b100 : (win == 1) ? 3'b010 : (win == 2) ? 3'b001 : 3'b000;
      chk("gnt", 32'({ld_gnt, cpu_gnt, vid_gnt}), 32'(eg));
      chk("ram_we", 32'(ram_we), 32'(w && a >= 12'd512));
      chk("rvalid", 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), rst_n ? 32'(m_rv) : 32'd0);
      chk("prot_err", 32'(prot_err), rst_n ? 32'(m_perr) : 32'd0);
      if (rst_n && m_rv != 3'b000) chk("rdata", 32'(rdata), 32'(m_rdata));
      if (win >= 0) chk("ram_addr", 32'(ram_addr), 32'(a));
      else if (rst_n) chk("ram_addr_hold", 32'(ram_addr), 32'(m_last));
      if (win >= 0 && w && a >= 12'd512) chk("ram_din", 32'(ram_din), 32'(d));
      // Advance to the next cycle.
      if (!rst_n) begin
         m_owner = 0; m_vid_first = 1'b0; m_rv = '0; m_perr = 1'b0;
         m_last = '0; m_win = -1;
      end else begin
         m_rv    = (win >= 0 && !w) ? eg : 3'b000;
         m_rdata = exp_mem[a];
         m_perr  = (win >= 0) && w && (a < 12'd512);
         if (win >= 0 && w && a >= 12'd512) exp_mem[a] = d;
         if (win >= 0) m_last = a;
         if (win == 1) m_vid_first = 1'b1;
         if (win == 2) m_vid_first = 1'b0;
         m_owner = own;
         if (own == 0 && win == 1 && cpu_lock) m_owner = 1;
         if (own == 0 && win == 2 && vid_lock) m_owner = 2;
         m_win = win;
      end
   endtask

   // One cycle with a hand-computed grant expectation plus the model check.
   task automatic hand_cycle(input string tag, input logic [2:0] e_gnt);
      @(negedge clk);
      chk(tag, 32'({ld_gnt, cpu_gnt, vid_gnt}), 32'(e_gnt));
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
      cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 0; vid_lock = 0; vid_addr = '0;
   endtask

   function automatic logic [11:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 12'($urandom);
      return 12'h1F8 + 12'($urandom_range(0, 15));
   endfunction

   typedef struct {
      logic        ld_req;  logic ld_we;  logic [11:0] ld_addr;  logic [7:0] ld_wdata;
      logic        cpu_req; logic cpu_we; logic cpu_lock; logic [11:0] cpu_addr; logic [7:0] cpu_wdata;
      logic        vid_req; logic vid_lock; logic [11:0] vid_addr;
      logic [2:0]  e_gnt;   logic e_we;   logic [2:0] e_rv;  logic e_perr;
      logic        rd_chk;  logic [7:0] e_rdata;
   } vec_t;

   vec_t tv [13];

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram_mem[i] = 8'(i) ^ 8'h3C;
         exp_mem[i] = 8'(i) ^ 8'h3C;
      end
      m_owner = 0; m_vid_first = 1'b0; m_rv = '0; m_rdata = '0; m_perr = 1'b0;
      m_last = '0; m_win = -1;

      // Directed vectors, applied from idle with all earlier reads retired.
      tv[0]  = '{1,1,12'h200,8'hA5, 0,0,0,12'h000,8'h00, 0,0,12'h000, 3'b100,1,3'b000,0, 0,8'h00};
      tv[1]  = '{0,0,12'h000,8'h00, 1,0,0,12'h200,8'h00, 0,0,12'h000, 3'b010,0,3'b000,0, 0,8'h00};
      tv[2]  = '{0,0,12'h000,8'h00, 1,0,0,12'h200,8'h00, 1,0,12'h010, 3'b001,0,3'b010,0, 1,8'hA5};
      tv[3]  = '{0,0,12'h000,8'h00, 1,0,0,12'h200,8'h00, 1,0,12'h011, 3'b010,0,3'b001,0, 1,8'h2C};
      tv[4]  = '{0,0,12'h000,8'h00, 1,1,0,12'h1FF,8'h77, 0,0,12'h000, 3'b010,0,3'b010,0, 1,8'hA5};
      tv[5]  = '{0,0,12'h000,8'h00, 1,1,0,12'h200,8'h77, 0,0,12'h000, 3'b010,1,3'b000,1, 0,8'h00};
      tv[6]  = '{0,0,12'h000,8'h00, 0,0,0,12'h000,8'h00, 0,0,12'h000, 3'b000,0,3'b000,0, 0,8'h00};
      tv[7]  = '{1,0,12'h300,8'h00, 1,0,0,12'h202,8'h00, 1,0,12'h012, 3'b100,0,3'b000,0, 0,8'h00};
      tv[8]  = '{0,0,12'h000,8'h00, 1,0,0,12'h202,8'h00, 1,0,12'h012, 3'b001,0,3'b100,0, 1,8'h3C};
      tv[9]  = '{0,0,12'h000,8'h00, 1,0,0,12'h200,8'h00, 0,0,12'h000, 3'b010,0,3'b001,0, 1,8'h2E};
      tv[10] = '{0,0,12'h000,8'h00, 0,0,0,12'h000,8'h00, 0,0,12'h000, 3'b000,0,3'b010,0, 1,8'h77};
      tv[11] = '{0,0,12'h000,8'h00, 1,0,0,12'h1FF,8'h00, 0,0,12'h000, 3'b010,0,3'b000,0, 0,8'h00};
      tv[12] = '{0,0,12'h000,8'h00, 0,0,0,12'h000,8'h00, 0,0,12'h000, 3'b000,0,3'b010,0, 1,8'hC3};

      // Reset held three cycles with every requester active.
      idle_all();
      rst_n = 0;
      ld_req = 1; ld_we = 1; ld_addr = 12'h250; ld_wdata = 8'h11;
      cpu_req = 1; cpu_addr = 12'h210;
      vid_req = 1; vid_addr = 12'h005;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) hand_cycle("reset_gnt", 3'b000);
      rst_n = 1;
      hand_cycle("first_after_reset", 3'b100);
      ld_req = 0;
      hand_cycle("ptr_reset_cpu", 3'b010);
      cpu_req = 0;
      hand_cycle("then_vid", 3'b001);
      idle_all();
      hand_cycle("idle", 3'b000);

      // Vector table.
      for (int i = 0; i < 13; i++) begin
         ld_req = tv[i].ld_req; ld_we = tv[i].ld_we; ld_addr = tv[i].ld_addr; ld_wdata = tv[i].ld_wdata;
         cpu_req = tv[i].cpu_req; cpu_we = tv[i].cpu_we; cpu_lock = tv[i].cpu_lock;
         cpu_addr = tv[i].cpu_addr; cpu_wdata = tv[i].cpu_wdata;
         vid_req = tv[i].vid_req; vid_lock = tv[i].vid_lock; vid_addr = tv[i].vid_addr;
         @(negedge clk);
         chk($sformatf("tv%0d_gnt", i), 32'({ld_gnt, cpu_gnt, vid_gnt}), 32'(tv[i].e_gnt));
         chk($sformatf("tv%0d_we", i), 32'(ram_we), 32'(tv[i].e_we));
         chk($sformatf("tv%0d_rvalid", i), 32'({ld_rvalid, cpu_rvalid, vid_rvalid}), 32'(tv[i].e_rv));
         chk($sformatf("tv%0d_prot_err", i), 32'(prot_err), 32'(tv[i].e_perr));
         if (tv[i].rd_chk) chk($sformatf("tv%0d_rdata", i), 32'(rdata), 32'(tv[i].e_rdata));
         model_step();
         @(posedge clk);
         #1;
      end
      idle_all();

      // Video lock burst holds off the loader and CPU.
      vid_req = 1; vid_lock = 1; vid_addr = 12'h000;
      hand_cycle("burst0", 3'b001);
      ld_req = 1; ld_addr = 12'h300; cpu_req = 1; cpu_addr = 12'h201;
      for (int i = 1; i < 4; i++) begin
         vid_addr = 12'(i);
         hand_cycle("burst_hold", 3'b001);
      end
      vid_req = 0; vid_lock = 0;
      hand_cycle("burst_release_ld", 3'b100);
      ld_req = 0;
      hand_cycle("burst_then_cpu", 3'b010);
      idle_all();
      hand_cycle("idle2", 3'b000);

      // Reset in the middle of a CPU lock burst.
      cpu_req = 1; cpu_lock = 1; cpu_addr = 12'h205;
      hand_cycle("cpu_lock0", 3'b010);
      cpu_addr = 12'h206; vid_req = 1; vid_addr = 12'h020;
      hand_cycle("cpu_lock1", 3'b010);
      rst_n = 0;
      @(negedge clk);
      chk("midburst_rst_rvalid", 32'(cpu_rvalid), 32'd0);
      model_step();
      @(posedge clk);
      #1;
      rst_n = 1; cpu_req = 0;
      hand_cycle("vid_after_rst", 3'b001);
      idle_all();
      hand_cycle("idle3", 3'b000);

      // Random traffic; a requester keeps its request until granted.
      for (int c = 0; c < 3000; c++) begin
         if (!ld_req || m_win == 0) begin
            ld_req = ($urandom_range(0, 7) == 0); ld_we = 1'($urandom_range(0, 1));
            ld_addr = rnd_addr(); ld_wdata = 8'($urandom);
         end
         if (!cpu_req || m_win == 1) begin
            cpu_req = 1'($urandom_range(0, 1)); cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = rnd_addr(); cpu_wdata = 8'($urandom);
         end
         if (!vid_req || m_win == 2) begin
            vid_req = 1'($urandom_range(0, 1)); vid_addr = rnd_addr();
         end
         if ($urandom_range(0, 7) == 0) cpu_lock = !cpu_lock;
         if ($urandom_range(0, 7) == 0) vid_lock = !vid_lock;
         rst_n = ($urandom_range(0, 99) != 0);
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port 4 KB CHIP-8 RAM (font ROM below 0x200, program/data RAM above) between three requesters: the ROM loader, the CPU core and the display/sprite fetcher.
- Issues at most one access per cycle.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Enforces write protection of the font/interpreter region.
- Supports locked multi-cycle ownership for sprite bursts.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 8, RAM data width.
- PROT_LIMIT, 512, writes to addresses below this value are suppressed.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- ld_req  in  1  loader request
- ld_we  in  1  loader write enable (1 = write, 0 = read)
- ld_addr  in  ADDR_W  loader address
- ld_wdata  in  DATA_W  loader write data
- ld_gnt  out  1  loader access issued this cycle
- ld_rvalid  out  1  ld read data valid on rdata
- cpu_req  in  1  CPU request
- cpu_we  in  1  CPU write enable
- cpu_lock  in  1  CPU holds ownership after grant
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid on rdata
- vid_req  in  1  video read request (read-only requester)
- vid_lock  in  1  video holds ownership after grant
- vid_addr  in  ADDR_W  video address
- vid_gnt  out  1  video access issued this cycle
- vid_rvalid  out  1  video read data valid on rdata
- rdata  out  DATA_W  read data, equals ram_dout
- prot_err  out  1  one-cycle pulse: suppressed protected write
- ram_addr  out  ADDR_W  to RAM addr
- ram_din  out  DATA_W  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DATA_W  from RAM dout (valid one cycle after address)

Behaviour:
- Reset (rst_n = 0 at rising edge):
  - state = IDLE, round-robin pointer = CPU.
  - All gnt, rvalid, prot_err = 0; ram_we = 0.
  - While rst_n is low, all gnt and ram_we are forced 0.
  - Reset mid-burst drops the lock. No rvalid is issued for an access granted in the cycle before reset.
- Grant is combinational in the cycle the access is presented to the RAM. ram_addr, ram_din and ram_we are muxed from the granted requester in the same cycle.
  - With no grant: ram_we = 0, ram_addr/ram_din = previous value (hold).
- Requester rules:
  - Holds req, addr, we and wdata stable until gnt is seen.
  - Each gnt consumes exactly one access.
  - Requester may deassert req in the gnt cycle.
- Read latency:
  - rvalid_x registered; asserted exactly one cycle after gnt_x with we = 0.
  - rdata = ram_dout in that cycle.
  - Writes never produce rvalid.
- Arbitration in IDLE:
  - ld_req has fixed top priority.
  - CPU and video alternate round-robin. The pointer moves to the other requester after each CPU/video grant, so the last-granted requester gets lower priority next time both request.
  - If only one of CPU/video requests, it is granted every cycle.
- State machine: IDLE, OWN_CPU, OWN_VID.
  - IDLE -> OWN_CPU when cpu_gnt and cpu_lock.
  - IDLE -> OWN_VID when vid_gnt and vid_lock.
  - In OWN_x, only x can be granted; the loader is blocked.
    - x granted each cycle it requests.
    - Stays in OWN_x while lock_x = 1, even if req_x = 0.
  - OWN_x -> IDLE on the first cycle lock_x = 0, evaluated before arbitration. Normal arbitration applies that same cycle.
  - The loader never locks.
- Write protection:
  - Granted write with addr < PROT_LIMIT: gnt asserted (access consumed), ram_we held 0, prot_err = 1 in the next cycle.
  - Addresses >= PROT_LIMIT up to 0xFFF are written normally.
- Simultaneous events:
  - All three requesting in IDLE: loader wins; pointer unchanged.
  - Lock asserted together with the loader request in IDLE: the loader still wins; lock takes effect only on an actual grant.
- No combinational path from ram_dout to any gnt.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with all req = 1 -> all gnt, rvalid, prot_err, ram_we = 0; the first grant after release goes to ld.
- Loader write 0xA5 to 0x200, then CPU read 0x200 -> ld_gnt, ram_we = 1 in cycle N; cpu_gnt in cycle N+1; cpu_rvalid = 1 and rdata = 0xA5 in cycle N+2; ld_rvalid stays 0.
- CPU and video both reading continuously, no lock -> grants alternate CPU, VID, CPU, VID; each rvalid follows its gnt by exactly one cycle.
- Video lock burst: vid_lock = 1 with 4 reads at 0x000 to 0x003 while ld_req and cpu_req are high -> 4 consecutive vid_gnt; ld_gnt in the cycle after vid_lock falls; then CPU.
- CPU write 0x77 to 0x1FF -> cpu_gnt = 1, ram_we = 0, prot_err = 1 the next cycle. The same write to 0x200 -> ram_we = 1, prot_err = 0.
- rst_n pulsed low in OWN_CPU mid-burst -> state IDLE, no rvalid for the pre-reset grant; vid_req is granted on the first cycle after release.
